// File: rtl/s_trunc32_17.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_trunc32_17                                                               |
// | Two-stage valid/ready signed narrowing of 32 bits to a 17-bit field, with  |
// | wrap/saturate selection and sticky, saturating overflow status.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module s_trunc32_17 (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        sat_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_data,
  output logic        out_ovf,
  input  logic        clr_status,
  output logic        ovf_sticky,
  output logic [7:0]  ovf_count
);

  localparam logic [16:0] C_SAT_POS = 17'h0FFFF;
  localparam logic [16:0] C_SAT_NEG = 17'h10000;
  localparam logic [7:0]  C_CNT_MAX = 8'hFF;

  logic        r_s1_valid;
  logic [16:0] r_s1_low;
  logic        r_s1_neg;
  logic        r_s1_sat;
  logic        r_s1_ovf;

  logic        r_out_valid;
  logic [16:0] r_out_data;
  logic        r_out_ovf;

  logic        r_ovf_sticky;
  logic [7:0]  r_ovf_count;

  logic        w_fit;
  logic        w_s2_load;
  logic        w_in_ready;
  logic        w_in_xfer;
  logic        w_ovf_evt;
  logic [16:0] w_s2_data;

  // Value fits in 17 signed bits when the upper 16 bits all copy the sign.
  assign w_fit      = (&in_data[31:16]) | ~(|in_data[31:16]);
  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_ovf_evt  = r_out_valid && out_ready && r_out_ovf;

  always_comb begin
    w_s2_data = r_s1_low;
    if (r_s1_sat && r_s1_ovf) begin
      w_s2_data = r_s1_neg ? C_SAT_NEG : C_SAT_POS;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_low   <= 17'd0;
      r_s1_neg   <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_ovf   <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_low   <= in_data[16:0];
      r_s1_neg   <= in_data[31];
      r_s1_sat   <= sat_en;
      r_s1_ovf   <= !w_fit;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 17'd0;
      r_out_ovf   <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_s2_data;
      r_out_ovf   <= r_s1_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A counted event in the same cycle as a clear survives the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= 8'd0;
    end else if (clr_status) begin
      r_ovf_sticky <= w_ovf_evt;
      r_ovf_count  <= w_ovf_evt ? 8'd1 : 8'd0;
    end else if (w_ovf_evt) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != C_CNT_MAX) begin
        r_ovf_count <= r_ovf_count + 8'd1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_s_trunc32_17.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_s_trunc32_17                                                            |
// | Self-checking bench for s_trunc32_17 against an arithmetic queue model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_s_trunc32_17;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_ovf;
  logic        clr_status;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  s_trunc32_17 dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .clr_status (clr_status),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [16:0] d;
    logic        o;
    bit          aged;
  } item_t;

  item_t q[$];
  int    ntests = 0;
  int    nfail  = 0;
  int    m_cnt  = 0;
  bit    m_st   = 0;
  bit    zflag  = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: narrowing computed on the signed integer value.
  function automatic item_t ref_narrow(input logic [31:0] d, input logic s);
    item_t r;
    int    sv;
    sv     = $signed(d);
    r.o    = !((sv >= -65536) && (sv <= 65535));
    r.d    = d[16:0];
    if (r.o && s) r.d = (sv < 0) ? 17'h10000 : 17'h0FFFF;
    r.aged = 0;
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] b [6];
    b[0] = 32'h0000FFFF; b[1] = 32'hFFFF0000; b[2] = 32'h00010000;
    b[3] = 32'hFFFEFFFF; b[4] = 32'h7FFFFFFF; b[5] = 32'h80000000;
    case ($urandom_range(0, 3))
      0:       return b[$urandom_range(0, 5)];
      1:       return 32'($signed($urandom_range(0, 140000)) - 70000);
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic s,
                     input logic ordy, input logic clr, input logic rst);
    logic  exp_ir, exp_ov, evt;
    item_t e;
    reset = rst; in_valid = v; in_data = d; sat_en = s;
    out_ready = ordy; clr_status = clr;
    @(negedge clock);
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && q[0].aged;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      chk("out_data", {15'd0, out_data}, {15'd0, q[0].d});
      chk("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].o});
    end else if (zflag) begin
      chk("rst_out_data", {15'd0, out_data}, 32'd0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    end
    chk("ovf_sticky", {31'd0, ovf_sticky}, {31'd0, m_st});
    chk("ovf_count", {24'd0, ovf_count}, m_cnt);
    if (rst) begin
      q.delete(); m_cnt = 0; m_st = 0; zflag = 1;
    end else begin
      evt = 0;
      if (exp_ov && ordy) begin
        e   = q.pop_front();
        evt = e.o;
      end
      if (clr) begin
        m_st = evt; m_cnt = evt ? 1 : 0;
      end else if (evt) begin
        m_st = 1;
        if (m_cnt < 255) m_cnt++;
      end
      foreach (q[i]) q[i].aged = 1;
      if (v && exp_ir) begin
        q.push_back(ref_narrow(d, s));
        zflag = 0;
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] dv [7];
    logic        sv [7];
    dv[0] = 32'h0000FFFF; sv[0] = 0;  dv[1] = 32'hFFFF0000; sv[1] = 0;
    dv[2] = 32'h00010000; sv[2] = 0;  dv[3] = 32'hFFFEFFFF; sv[3] = 0;
    dv[4] = 32'h7FFFFFFF; sv[4] = 1;  dv[5] = 32'h80000000; sv[5] = 1;
    dv[6] = 32'h00001234; sv[6] = 1;

    reset = 1; in_valid = 0; in_data = 0; sat_en = 0; out_ready = 0; clr_status = 0;
    repeat (2) @(posedge clock);
    #1;
    cyc(0, 0, 0, 0, 0, 1);

    // Directed boundary and saturation values, unstalled.
    for (int i = 0; i < 7; i++) cyc(1, dv[i], sv[i], 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Backpressure: out_ready pattern 1,0,0,1 repeating.
    for (int i = 0; i < 16; i++)
      cyc(1, rand_data(), 1'($urandom_range(0, 1)), ((i % 4) == 0) || ((i % 4) == 3), 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);

    // Random traffic, with data wiggling while stalled.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);

    // Saturating counter.
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 260; i++) cyc(1, 32'h00020000 + 32'(i), 1'(i & 1), 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    chk("count_sat", {24'd0, ovf_count}, 32'd255);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Clear coincident with an overflowed transfer.
    cyc(1, 32'h80000000, 0, 0, 0, 0);
    cyc(1, 32'h00000005, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Reset with both stages full, then post-reset latency.
    cyc(1, 32'h40000000, 0, 1, 0, 0);
    cyc(1, 32'h00000077, 1, 0, 0, 0);
    cyc(1, 32'h00000088, 1, 0, 0, 0);
    cyc(1, 32'h00000099, 1, 0, 0, 1);
    cyc(1, 32'hFFFFFFFE, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
